// File: rtl/imem_fetch_ctrl.sv
// Instruction memory with a loader phase and a 1-cycle fetch port.
// Define IMEM_ERR_CHECK_EN to trap misaligned / out-of-range fetches.
`timescale 1ns/1ps
module imem_fetch_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_we,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              ld_done,
  output logic [IDX_W:0]    ld_count,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  input  logic              f_stall,
  output logic              f_valid,
  output logic [WIDTH-1:0]  f_instr,
  output logic              f_err
);

`ifdef IMEM_ERR_CHECK_EN
  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_ERR
  } state_t;
`else
  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN
  } state_t;
`endif

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(DEPTH);

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             accept;

  assign idx     = f_addr[IDX_W+1:2];
  assign f_ready = (state == S_RUN) && !(f_valid && f_stall) && !ld_start;
  assign accept  = f_req && f_ready;

`ifdef IMEM_ERR_CHECK_EN
  logic bad_addr;
  assign bad_addr = (f_addr[1:0] != 2'b00) ||
                    ((f_addr >> 2) >= ADDR_W'(DEPTH));
`else
  // Low and high address bits are don't-care; index wraps modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^f_addr;
  assign f_err       = 1'b0;
`endif

  // Array has no reset so contents survive rst and reloads.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && ld_we)
      mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_LOAD;
      f_valid  <= 1'b0;
      f_instr  <= '0;
      ld_count <= '0;
`ifdef IMEM_ERR_CHECK_EN
      f_err    <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (ld_we && ld_count != CNT_MAX)
            ld_count <= ld_count + 1'b1;
          if (ld_done)
            state <= S_RUN;
        end
        S_RUN: begin
          if (ld_start) begin
            state    <= S_LOAD;
            f_valid  <= 1'b0;
            ld_count <= '0;
`ifdef IMEM_ERR_CHECK_EN
            f_err    <= 1'b0;
`endif
          end else if (accept) begin
`ifdef IMEM_ERR_CHECK_EN
            if (bad_addr) begin
              state   <= S_ERR;
              f_err   <= 1'b1;
              f_valid <= 1'b0;
              f_instr <= '0;
            end else
`endif
            begin
              f_valid <= 1'b1;
              f_instr <= mem[idx];
            end
          end else if (!(f_valid && f_stall)) begin
            f_valid <= 1'b0;
          end
        end
`ifdef IMEM_ERR_CHECK_EN
        S_ERR: begin
          if (ld_start) begin
            state    <= S_LOAD;
            f_err    <= 1'b0;
            f_valid  <= 1'b0;
            ld_count <= '0;
          end
        end
`endif
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: directed load/fetch/stall/reset.
// Covers the IMEM_ERR_CHECK_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = $clog2(DEPTH);

  logic              clk;
  logic              rst;
  logic              ld_start;
  logic              ld_we;
  logic [IDX_W-1:0]  ld_addr;
  logic [WIDTH-1:0]  ld_data;
  logic              ld_done;
  logic [IDX_W:0]    ld_count;
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ready;
  logic              f_stall;
  logic              f_valid;
  logic [WIDTH-1:0]  f_instr;
  logic              f_err;

  imem_fetch_ctrl #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ld_start(ld_start),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ld_done (ld_done),
    .ld_count(ld_count),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_ready (f_ready),
    .f_stall (f_stall),
    .f_valid (f_valid),
    .f_instr (f_instr),
    .f_err   (f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sb[$];
  int ntot  = 0;
  int npass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
    f_req  = 1'b1;
    f_addr = a;
    sb.push_back(exp);
  endtask

  // Monitor: a word transfers when valid and not stalled.
  always @(negedge clk) begin
    if (!rst && f_valid && !f_stall) begin
      if (sb.size() == 0) begin
        ntot++;
        $display("FAIL unexpected_word: got %h expected none", f_instr);
      end else begin
        chk("sb_word", f_instr, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ld_start = 0; ld_we = 0; ld_addr = '0; ld_data = '0;
    ld_done = 0; f_req = 0; f_addr = '0; f_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(f_valid), 0);
    chk("rst_instr", f_instr, 0);
    chk("rst_err", 32'(f_err), 0);
    chk("rst_count", 32'(ld_count), 0);
    chk("rst_ready", 32'(f_ready), 0);
    rst = 1'b0;
    tick();

    // load four words, ld_done with the last write
    for (int i = 0; i < 4; i++) begin
      ld_we   = 1'b1;
      ld_addr = IDX_W'(i);
      ld_data = 32'h11111111 * (i + 1);
      ld_done = (i == 3);
      tick();
    end
    ld_we = 0; ld_done = 0;
    #1;
    chk("load_count", 32'(ld_count), 4);
    chk("run_ready", 32'(f_ready), 1);

    // back-to-back burst
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4), 32'h11111111 * (i + 1));
      tick();
      chk("burst_valid", 32'(f_valid), 1);
    end
    f_req = 0;
    tick();
    chk("idle_valid", 32'(f_valid), 0);
    chk("idle_instr_hold", f_instr, 32'h44444444);

    // stall holds the output for three cycles
    fetch(32'h4, 32'h22222222);
    tick();
    f_stall = 1'b1;
    fetch(32'h8, 32'h33333333);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_ready", 32'(f_ready), 0);
      tick();
      chk("stall_valid", 32'(f_valid), 1);
      chk("stall_instr", f_instr, 32'h22222222);
    end
    f_stall = 1'b0;
    #1;
    chk("unstall_ready", 32'(f_ready), 1);
    tick();
    chk("after_stall", f_instr, 32'h33333333);
    f_req = 0;
    tick();
    chk("after_stall_idle", 32'(f_valid), 0);

    // ld_start beats a simultaneous f_req
    fetch(32'h0, 32'h11111111);
    tick();
    ld_start = 1'b1;
    f_addr   = 32'h4;
    #1;
    chk("ldstart_ready", 32'(f_ready), 0);
    tick();
    ld_start = 0; f_req = 0;
    chk("ldstart_valid", 32'(f_valid), 0);
    chk("ldstart_count", 32'(ld_count), 0);
    chk("load_ready", 32'(f_ready), 0);
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    #1;
    chk("reload_ready", 32'(f_ready), 1);
    fetch(32'h0, 32'h11111111);
    tick();
    f_req = 0;
    tick();

`ifdef IMEM_ERR_CHECK_EN
    for (int e = 0; e < 2; e++) begin
      f_req  = 1'b1;
      f_addr = (e == 0) ? 32'h2 : 32'(DEPTH * 4);
      tick();
      chk("err_flag", 32'(f_err), 1);
      chk("err_valid", 32'(f_valid), 0);
      chk("err_instr", f_instr, 0);
      chk("err_ready", 32'(f_ready), 0);
      tick();
      chk("err_hold_ready", 32'(f_ready), 0);
      chk("err_hold_flag", 32'(f_err), 1);
      f_req = 0; ld_start = 1'b1;
      tick();
      ld_start = 0;
      chk("err_clear", 32'(f_err), 0);
      ld_done = 1'b1;
      tick();
      ld_done = 0;
    end
`else
    fetch(32'(DEPTH * 4), 32'h11111111);
    tick();
    fetch(32'h7, 32'h22222222);
    tick();
    f_req = 0;
    tick();
    chk("no_err", 32'(f_err), 0);
`endif
    chk("sb_drained", 32'(sb.size()), 0);

    // asynchronous reset mid-stream
    fetch(32'hC, 32'h44444444);
    tick();
    chk("pre_rst_valid", 32'(f_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(f_valid), 0);
    chk("arst_instr", f_instr, 0);
    chk("arst_err", 32'(f_err), 0);
    chk("arst_count", 32'(ld_count), 0);
    chk("arst_ready", 32'(f_ready), 0);
    sb.delete();
    f_req = 0;
    tick();
    rst = 1'b0;
    tick();

    // ld_count saturates at DEPTH
    ld_we = 1'b1; ld_addr = IDX_W'(8); ld_data = 32'hDEADBEEF;
    repeat (DEPTH + 2) tick();
    ld_we = 1'b0;
    chk("count_sat", 32'(ld_count), DEPTH);
    ld_done = 1'b1;
    tick();
    ld_done = 0;
    fetch(32'h0, 32'h11111111);
    tick();
    fetch(32'h20, 32'hDEADBEEF);
    tick();
    f_req = 0;
    repeat (2) tick();
    chk("final_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameters, one per line:
  WIDTH, 32, instruction word width in bits
  DEPTH, 1024, number of instruction words (power of two, >= 4)
  ADDR_W, 32, fetch byte-address width
  IDX_W, $clog2(DEPTH), derived word-index width, not overridden
REQ-002 The block SHALL have ports, one per line:
  clk  in  1  clock; all state updates on rising edge
  rst  in  1  asynchronous, active-high reset
  ld_start  in  1  request entry to LOAD state
  ld_we  in  1  loader write strobe
  ld_addr  in  IDX_W  loader word index
  ld_data  in  WIDTH  loader write data
  ld_done  in  1  loader finished; enter RUN
  ld_count  out  IDX_W+1  writes accepted in the current load session
  f_req  in  1  fetch request
  f_addr  in  ADDR_W  fetch byte address
  f_ready  out  1  request accepted this cycle when f_req also high
  f_stall  in  1  consumer cannot take f_instr this cycle
  f_valid  out  1  f_instr holds a fetched word
  f_instr  out  WIDTH  fetched instruction
  f_err  out  1  sticky fetch address error
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states LOAD, RUN and, only with IMEM_ERR_CHECK_EN, ERR.
REQ-005 LOAD: ld_we=1 SHALL write ld_data to mem[ld_addr] at the clock edge; ld_count SHALL increment per write and saturate at DEPTH; f_ready=0 and f_req SHALL be ignored.
REQ-006 LOAD: ld_done=1 SHALL move to RUN next cycle; ld_we and ld_done in the same cycle SHALL perform the write and then transition.
REQ-007 RUN: ld_we SHALL be ignored; memory contents SHALL persist across all state changes and reset.
REQ-008 RUN: f_ready SHALL be 1 unless (f_valid && f_stall) or ld_start; f_ready is combinational.
REQ-009 A request is accepted when f_req && f_ready; word index = f_addr[IDX_W+1:2]; the next cycle f_valid=1 and f_instr=mem[index] (1-cycle latency).
REQ-010 Back-to-back accepted requests SHALL produce one valid word per cycle, in order, no bubbles.
REQ-011 While f_valid && f_stall, f_valid and f_instr SHALL hold unchanged and no request is accepted.
REQ-012 If f_valid is 0 or f_stall is 0 and no request is accepted, f_valid SHALL go 0 next cycle; f_instr SHALL keep its last value.
REQ-013 ld_start in RUN or ERR SHALL move to LOAD next cycle, clear f_valid, f_err and ld_count, and take precedence over a simultaneous f_req.
REQ-014 Without IMEM_ERR_CHECK_EN, f_addr[1:0] and bits above IDX_W+1 SHALL be ignored (index wraps modulo DEPTH).

Reset
REQ-015 On rst=1, asynchronously: state=LOAD, f_valid=0, f_instr=0, f_err=0, ld_count=0; f_ready=0 while in LOAD.
REQ-016 Reset mid-fetch SHALL discard the in-flight word; memory array SHALL not be cleared.

Configuration
REQ-017 Macro IMEM_ERR_CHECK_EN defined: an accepted request with f_addr[1:0]!=0 or (f_addr>>2)>=DEPTH SHALL, next cycle, enter ERR with f_err=1, f_valid=0, f_instr=0; ERR SHALL hold f_ready=0 until rst or ld_start; earlier valid words already delivered are unaffected.
REQ-018 Macro IMEM_ERR_CHECK_EN undefined: no ERR state, f_err SHALL be constant 0, addressing per REQ-014.

Verification
REQ-019 Load words 0..3 = 0x11111111..0x44444444, ld_done -> ld_count=4, RUN next cycle, f_ready=1.
REQ-020 f_req on 4 consecutive cycles at f_addr 0x0,0x4,0x8,0xC -> f_valid=1 for 4 cycles from next cycle, f_instr 0x11111111..0x44444444 in order.
REQ-021 f_stall=1 for 3 cycles while f_instr=0x22222222 -> f_instr/f_valid held, f_ready=0, next word 0x33333333 after stall drops.
REQ-022 ld_start asserted with f_req in the same cycle -> request not accepted, state LOAD, f_valid=0, ld_count=0; memory still returns 0x11111111 at address 0 after reload-free ld_done.
REQ-023 With IMEM_ERR_CHECK_EN, f_addr=0x2 and separately f_addr=DEPTH*4 -> f_err=1, f_valid=0, f_ready=0 until ld_start; without macro, f_addr=DEPTH*4 returns word 0.
REQ-024 rst pulsed asynchronously mid-stream -> f_valid, f_instr, f_err, ld_count immediately 0, state LOAD.
